// File: rtl/regfile_dump.sv
// regfile_dump: walks register-file addresses 0..NREGS-1 through an
// asynchronous read port and streams each value out over a valid/ready
// handshake, one word every two cycles at full throughput.
//
// Optional feature: define REGDUMP_CSUM_EN to append a 33rd word (out_idx=32)
// carrying the XOR of all dumped words.
//
// Ports:
//   clk       - single clock, rising edge
//   rstn      - asynchronous active-low reset
//   start     - dump request, honoured only while idle
//   rd_addr   - register-file read address (equals idx[4:0])
//   rd_data   - combinational register-file read data for rd_addr
//   out_valid - out_data/out_idx hold a word
//   out_ready - sink accepts the word this cycle
//   out_data  - dumped value (registered)
//   out_idx   - index of out_data (0..NREGS-1, or 32 for the checksum)
//   busy      - high whenever the controller is not idle
//   done      - one-cycle pulse when the dump completes
module regfile_dump #(
  parameter int NREGS = 32
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  output logic [4:0]  rd_addr,
  input  logic [31:0] rd_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [5:0]  out_idx,
  output logic        busy,
  output logic        done
);

`ifdef REGDUMP_CSUM_EN
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_SEND = 3'd2,
    S_CSUM = 3'd3,
    S_DONE = 3'd4
  } state_e;
`else
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_SEND = 3'd2,
    S_DONE = 3'd4
  } state_e;
`endif

  localparam logic [5:0] LAST_IDX = 6'(NREGS - 1);
`ifdef REGDUMP_CSUM_EN
  localparam logic [5:0] CSUM_IDX = 6'd32;
`endif

  state_e      state_q, state_d;
  logic [5:0]  idx_q, idx_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_data_q, out_data_d;
  logic [5:0]  out_idx_q, out_idx_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
`ifdef REGDUMP_CSUM_EN
  logic [31:0] csum_q, csum_d;
`endif

  logic        xfer_s;

  assign xfer_s    = out_valid_q && out_ready;
  assign rd_addr   = idx_q[4:0];
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign busy      = busy_q;
  assign done      = done_q;

  // Next-state and next-output computation for the dump sequencer.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
`ifdef REGDUMP_CSUM_EN
    csum_d      = csum_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          idx_d   = 6'd0;
          state_d = S_LOAD;
`ifdef REGDUMP_CSUM_EN
          csum_d  = 32'd0;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        // Each word is a fresh sample of the register file at this cycle.
        out_data_d  = rd_data;
        out_idx_d   = idx_q;
        out_valid_d = 1'b1;
`ifdef REGDUMP_CSUM_EN
        csum_d      = csum_q ^ rd_data;
`endif
        state_d     = S_SEND;
      end
      S_SEND: begin
        if (xfer_s) begin
          out_valid_d = 1'b0;
          if (idx_q == LAST_IDX) begin
`ifdef REGDUMP_CSUM_EN
            state_d = S_CSUM;
`else
            state_d = S_DONE;
`endif
          end else begin
            idx_d   = idx_q + 6'd1;
            state_d = S_LOAD;
          end
        end else begin
          state_d = S_SEND;
        end
      end
`ifdef REGDUMP_CSUM_EN
      S_CSUM: begin
        // First CSUM cycle presents the checksum word; it then holds until taken.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_data_d  = csum_q;
          out_idx_d   = CSUM_IDX;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_DONE;
        end else begin
          state_d     = S_CSUM;
        end
      end
`endif
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
    // Status outputs are registered against the state being entered.
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      idx_q       <= 6'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= 32'd0;
      out_idx_q   <= 6'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef REGDUMP_CSUM_EN
      csum_q      <= 32'd0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef REGDUMP_CSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

endmodule

// File: doc/regfile_dump.md
REGFILE_DUMP -- requirements
Module: regfile_dump

Interface
REQ-001 SHALL have parameter NREGS, default 32, the number of registers dumped, starting at address 0; legal range 1..32.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rstn, input, 1, reset; reset is asynchronous and active-low.
REQ-004 SHALL have port start, input, 1, dump request; sampled only in IDLE.
REQ-005 SHALL have port rd_addr, output, 5, read address driven to the register file's asynchronous read port.
REQ-006 SHALL have port rd_data, input, 32, combinational read data returned for rd_addr.
REQ-007 SHALL have port out_valid, output, 1, out_data/out_idx hold a word.
REQ-008 SHALL have port out_ready, input, 1, the sink accepts the word this cycle.
REQ-009 SHALL have port out_data, output, 32, dumped register value, registered.
REQ-010 SHALL have port out_idx, output, 6, index of out_data (0..NREGS-1, or 32 for checksum).
REQ-011 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-012 SHALL have port done, output, 1, one-cycle pulse at end of dump.

Function
REQ-013 SHALL implement states IDLE, LOAD, SEND, CSUM, DONE, with a registered index counter idx (6 bits).
REQ-014 IDLE: start=1 at a rising edge SHALL clear idx to 0 and enter LOAD; start=0 stays in IDLE.
REQ-015 rd_addr SHALL equal idx[4:0] combinationally in all states.
REQ-016 LOAD: at the next rising edge, SHALL capture rd_data into out_data, idx into out_idx, set out_valid=1, and enter SEND.
REQ-017 SEND: out_valid, out_data, and out_idx SHALL stay stable until out_valid && out_ready at a rising edge.
REQ-018 SEND transfer with idx < NREGS-1: SHALL set idx+1 and out_valid=0, and enter LOAD.
REQ-019 SEND transfer with idx = NREGS-1: SHALL enter CSUM if REGDUMP_CSUM_EN is defined, otherwise DONE; out_valid=0.
REQ-020 Throughput SHALL be one word per two cycles with out_ready held high; the first out_valid SHALL be asserted one cycle after start is sampled.
REQ-021 DONE: SHALL assert done=1 for exactly one cycle, then return to IDLE; busy=0 from the following cycle.
REQ-022 A start asserted while busy=1 SHALL be ignored and not queued.
REQ-023 A start sampled in the same cycle busy drops (first IDLE cycle) SHALL begin a new dump.
REQ-024 Each word SHALL reflect the register file contents at its LOAD cycle; a register-file write occurring mid-dump is visible only in later-loaded words, and no snapshot atomicity is provided.
REQ-025 out_ready held low SHALL stall indefinitely in SEND, with no word dropped or duplicated.

Reset
REQ-026 rstn=0 SHALL asynchronously force state IDLE, idx=0, out_valid=0, out_data=0, out_idx=0, busy=0, done=0, and the checksum accumulator to 0, including mid-dump (dump aborted, no done pulse).
REQ-027 After rstn deasserts, the block SHALL wait in IDLE for a new start.

Configuration
REQ-028 Macro REGDUMP_CSUM_EN defined: SHALL keep a 32-bit accumulator, cleared on start, XORed with each captured word in LOAD.
REQ-029 With REGDUMP_CSUM_EN, CSUM state SHALL present out_data=accumulator, out_idx=32, out_valid=1, hold under REQ-017 rules, and enter DONE on transfer.
REQ-030 Macro REGDUMP_CSUM_EN undefined: SHALL omit the accumulator and CSUM state; the dump is exactly NREGS words, and out_idx never equals 32.

Verification
REQ-031 Bench SHALL cover: regfile preloaded r[i]=0x1000_0000+i, start pulse, out_ready=1 -> 32 words, idx 0..31, data 0x1000_0000..0x1000_001F, done one cycle after the last transfer, 64 cycles start-to-last-transfer.
REQ-032 Bench SHALL cover: the same preload with out_ready toggled pseudo-randomly -> identical word sequence, data stable while out_valid && !out_ready.
REQ-033 Bench SHALL cover: REGDUMP_CSUM_EN defined, r[i]=i -> 33rd word out_idx=32, out_data=0x0000_0000 (XOR of 0..31); r[5]=0xFFFF_FFFF -> checksum 0xFFFF_FFFA.
REQ-034 Bench SHALL cover: rstn pulled low during word 10 -> out_valid=0, busy=0, done never asserts; a new start restarts at idx 0.
REQ-035 Bench SHALL cover: start held high continuously -> back-to-back dumps, with exactly one done pulse per 32-word dump and no overlap.
REQ-036 Bench SHALL cover: NREGS=4 -> words idx 0..3 only, then done (or checksum at idx 32 when enabled).
